// File: rtl/ahb_delay_pipe.sv
// ahb_delay_pipe
// Elastic delay line: WIDTH-bit beats pass through DEPTH register stages with a
// valid/ready handshake. An unstalled beat takes DEPTH edges to reach the output.
// Empty stages absorb stalls, so bubbles collapse under back-pressure.
// A flush discards every in-flight beat.
//
// Parameters:
//   WIDTH     beat width in bits (>= 1)
//   DEPTH     number of register stages (>= 1)
// Ports:
//   clk       clock, rising edge
//   reset_n   asynchronous active-low reset
//   flush     synchronous discard of all in-flight beats; blocks input that cycle
//   in_valid  upstream beat present
//   in_data   upstream beat
//   in_ready  a beat is accepted this cycle (combinational from out_ready/flush)
//   out_valid final stage holds a beat (registered)
//   out_data  final-stage beat (registered)
//   out_ready downstream accepts a beat this cycle
//   count     occupied stages; exists only when DELAY_COUNT_EN is defined
//
// Build option: define DELAY_COUNT_EN to add the count port and its counter.
module ahb_delay_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready
`ifdef DELAY_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] adv;

    // A stage may advance when it is empty or everything downstream moves.
    // The chain is built from the output backwards so that one out_ready
    // ripples through every full stage in the same cycle.
    always_comb begin
        logic chain;
        chain = out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = !v_q[i] || chain;
            adv[i] = chain;
        end
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            // Valid bits clear; data registers keep their values.
            v_d = '0;
        end else begin
            if (adv[0]) begin
                v_d[0] = in_valid && in_ready;
                if (in_valid && in_ready) begin
                    data_d[0] = in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    // Loading a bubble leaves the old data in place.
                    if (v_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef DELAY_COUNT_EN
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic          acc, del;

    assign acc = in_valid && in_ready;
    assign del = out_valid && out_ready;

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(acc) - CW'(del);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_ahb_delay_pipe.sv
// Self-checking bench for ahb_delay_pipe: random stimulus in phases (streaming,
// back-pressure, mixed, sparse), occasional flush and mid-stream resets.
// A position-based queue model predicts the cycle-exact outputs; a scoreboard
// of accepted beats is checked by an independent monitor at every transfer.
module tb_ahb_delay_pipe;

    localparam int W = 32;
    localparam int D = 3;
    localparam int NCYC = 3000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
`ifdef DELAY_COUNT_EN
    logic [$clog2(D+1)-1:0] count;
`endif

    ahb_delay_pipe #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DELAY_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: in-flight beats, oldest first, each with its stage position.
    typedef struct {
        logic [W-1:0] data;
        int           pos;
    } beat_t;

    beat_t        mq[$];
    logic [W-1:0] last_out = '0;   // last beat that reached the output stage
    logic [W-1:0] sb[$];           // scoreboard of expected deliveries

    function automatic bit m_in_ready(input bit fl, input bit ordy);
        return !fl && ((mq.size() < D) || ordy);
    endfunction

    function automatic void m_step(input bit fl, input bit iv, input logic [W-1:0] id,
                                   input bit ordy);
        bit acc;
        int lim;
        beat_t nb;
        acc = iv && m_in_ready(fl, ordy);
        if (fl) begin
            mq.delete();
            return;
        end
        if (mq.size() > 0 && mq[0].pos == D - 1 && ordy) begin
            void'(mq.pop_front());
        end
        // Each beat moves up one position if the slot ahead is free after
        // the beat in front of it has moved.
        lim = D;
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].pos + 1 < lim) begin
                mq[k].pos = mq[k].pos + 1;
            end
            lim = mq[k].pos;
        end
        if (acc) begin
            nb.data = id;
            nb.pos  = 0;
            mq.push_back(nb);
        end
        if (mq.size() > 0 && mq[0].pos == D - 1) begin
            last_out = mq[0].data;
        end
    endfunction

    task automatic check_outputs(input string tag);
        bit exp_v;
        exp_v = (mq.size() > 0) && (mq[0].pos == D - 1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(exp_v));
        chk({tag, "_out_data"}, 64'(out_data), 64'(last_out));
`ifdef DELAY_COUNT_EN
        chk({tag, "_count"}, 64'(count), 64'(mq.size()));
`endif
    endtask

    // Monitor: a transfer happens on the next edge when valid and ready are both
    // high mid-cycle; the delivered beat must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow at %0t: got %0h expected none", $time, out_data);
                end else begin
                    chk("sb_data", 64'(out_data), 64'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        bit exp_rdy;
        int phase;
        #1;
        check_outputs("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        #6;
        reset_n = 1'b1;
        for (int c = 0; c < NCYC + D + 2; c++) begin
            if (c == 700 || c == 1900) begin
                // Asynchronous reset in the middle of traffic.
                reset_n = 1'b0;
                #1;
                mq.delete();
                sb.delete();
                last_out = '0;
                check_outputs("midreset");
                chk("midreset_in_ready", 64'(in_ready), 64'd1);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                #1;
            end
            if (c >= NCYC) begin
                in_valid  = 1'b0;
                flush     = 1'b0;
                out_ready = 1'b1;
            end else begin
                phase    = (c / 64) % 4;
                in_data  = $urandom;
                flush    = ($urandom_range(39, 0) == 0);
                case (phase)
                    0: begin
                        in_valid  = 1'b1;
                        out_ready = 1'b1;
                    end
                    1: begin
                        in_valid  = ($urandom_range(9, 0) < 8);
                        out_ready = ($urandom_range(9, 0) == 0);
                    end
                    2: begin
                        in_valid  = $urandom_range(1, 0) == 1;
                        out_ready = $urandom_range(1, 0) == 1;
                    end
                    default: begin
                        in_valid  = ($urandom_range(9, 0) < 2);
                        out_ready = ($urandom_range(9, 0) < 3);
                    end
                endcase
            end
            #1;
            exp_rdy = m_in_ready(flush, out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (exp_rdy && in_valid) begin
                sb.push_back(in_data);
            end
            @(posedge clk);
            m_step(flush, in_valid, in_data, out_ready);
            if (flush) begin
                sb.delete();
            end
            #1;
            check_outputs("cycle");
            #1;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
